// File: rtl/mips_mem_responder.sv
// Single-ported word memory shared by the fetch and data ports. The data port has priority, and a starvation guard lets a waiting fetch through.
// Optional store protection of the low words is enabled with `define MIPS_MEM_WRITE_PROTECT_EN.
module mips_mem_responder #(
  parameter int DEPTH        = 1024,
  parameter int STARVE_LIMIT = 4,
  parameter int PROT_LIMIT   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rsp_data,
  output logic        i_rsp_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_req_we,
  input  logic [31:0] d_req_addr,
  input  logic [31:0] d_req_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rsp_data,
  output logic        d_rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

`ifdef MIPS_MEM_WRITE_PROTECT_EN
  localparam logic PROT_EN = 1'b1;
`else
  localparam logic PROT_EN = 1'b0;
`endif

  logic [31:0]   r_mem [DEPTH];
  logic [CW-1:0] r_starve_cnt;
  logic          r_starve_prio;
  logic          r_i_rsp_valid;
  logic [31:0]   r_i_rsp_data;
  logic          r_i_rsp_err;
  logic          r_d_rsp_valid;
  logic [31:0]   r_d_rsp_data;
  logic          r_d_rsp_err;

  logic          w_i_ready;
  logic          w_d_ready;
  logic          w_i_acc;
  logic          w_d_acc;
  logic [31:0]   w_addr;
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_prot;
  logic          w_wr_en;
  logic [31:0]   w_rd_word;
  logic [CW-1:0] w_cnt_nxt;

  assign w_i_ready = r_starve_prio ? 1'b1 : !d_req_valid;
  assign w_d_ready = r_starve_prio ? !i_req_valid : 1'b1;
  assign w_i_acc   = i_req_valid && w_i_ready;
  assign w_d_acc   = d_req_valid && w_d_ready;

  // The two accepts are mutually exclusive, so one address mux feeds the single port.
  assign w_addr     = w_i_acc ? i_req_addr : d_req_addr;
  assign w_idx      = w_addr[AW-1:0];
  assign w_in_range = (w_addr < 32'(DEPTH));
  assign w_rd_word  = r_mem[w_idx];
  assign w_prot     = PROT_EN && (d_req_addr < 32'(PROT_LIMIT));
  assign w_wr_en    = w_d_acc && d_req_we && w_in_range && !w_prot;

  always_comb begin
    w_cnt_nxt = r_starve_cnt;
    if (!i_req_valid || w_i_acc)
      w_cnt_nxt = '0;
    else if (r_starve_cnt != CW'(STARVE_LIMIT))
      w_cnt_nxt = r_starve_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[w_idx] <= d_req_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve_cnt  <= '0;
      r_starve_prio <= 1'b0;
      r_i_rsp_valid <= 1'b0;
      r_i_rsp_data  <= '0;
      r_i_rsp_err   <= 1'b0;
      r_d_rsp_valid <= 1'b0;
      r_d_rsp_data  <= '0;
      r_d_rsp_err   <= 1'b0;
    end else begin
      r_starve_cnt  <= w_cnt_nxt;
      r_starve_prio <= (w_cnt_nxt == CW'(STARVE_LIMIT));
      r_i_rsp_valid <= w_i_acc;
      r_d_rsp_valid <= w_d_acc;
      r_i_rsp_err   <= w_i_acc && !w_in_range;
      r_d_rsp_err   <= w_d_acc && (!w_in_range || (d_req_we && w_prot));
      if (w_i_acc)
        r_i_rsp_data <= w_in_range ? w_rd_word : 32'h0;
      if (w_d_acc)
        r_d_rsp_data <= (w_in_range && !d_req_we) ? w_rd_word : 32'h0;
    end
  end

  assign i_req_ready = w_i_ready;
  assign d_req_ready = w_d_ready;
  assign i_rsp_valid = r_i_rsp_valid;
  assign i_rsp_data  = r_i_rsp_data;
  assign i_rsp_err   = r_i_rsp_err;
  assign d_rsp_valid = r_d_rsp_valid;
  assign d_rsp_data  = r_d_rsp_data;
  assign d_rsp_err   = r_d_rsp_err;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Directed bench for mips_mem_responder (DEPTH=1024, STARVE_LIMIT=4, PROT_LIMIT=256).
module tb_mips_mem_responder;

`ifdef MIPS_MEM_WRITE_PROTECT_EN
  localparam logic [31:0] BASE = 32'd256;
`else
  localparam logic [31:0] BASE = 32'd0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_valid = 1'b0;
  logic        i_req_ready;
  logic [31:0] i_req_addr = '0;
  logic        i_rsp_valid;
  logic [31:0] i_rsp_data;
  logic        i_rsp_err;
  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic        d_req_we = 1'b0;
  logic [31:0] d_req_addr = '0;
  logic [31:0] d_req_wdata = '0;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;

  int checks = 0;
  int failures = 0;
  logic exp_i;

  mips_mem_responder #(.DEPTH(1024), .STARVE_LIMIT(4), .PROT_LIMIT(256)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data), .i_rsp_err(i_rsp_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
    .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data), .d_rsp_err(d_rsp_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic d_store(input logic [31:0] a, input logic [31:0] wd);
    d_req_valid = 1'b1; d_req_we = 1'b1; d_req_addr = a; d_req_wdata = wd;
  endtask

  task automatic d_load(input logic [31:0] a);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_addr = a; d_req_wdata = '0;
  endtask

  task automatic d_idle();
    d_req_valid = 1'b0; d_req_we = 1'b0;
  endtask

  initial begin
    // reset state
    tick(); tick();
    chk("rst_i_rsp_valid", 32'(i_rsp_valid), 32'd0);
    chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("rst_d_rsp_data",  d_rsp_data, 32'd0);
    chk("rst_i_rsp_data",  i_rsp_data, 32'd0);
    chk("rst_starve_cnt",  32'(dut.r_starve_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // preload words 0..2
    for (int k = 0; k < 3; k++) begin
      d_store(BASE + 32'(k), 32'h1111_0000 + 32'(k));
      tick();
      chk("pre_store_valid", 32'(d_rsp_valid), 32'd1);
      chk("pre_store_err",   32'(d_rsp_err), 32'd0);
    end

    // store then immediate load of the same word
    d_store(BASE + 32'd5, 32'hDEAD_BEEF);
    tick();
    chk("st5_valid", 32'(d_rsp_valid), 32'd1);
    chk("st5_err",   32'(d_rsp_err), 32'd0);
    chk("st5_data",  d_rsp_data, 32'd0);
    d_load(BASE + 32'd5);
    tick();
    chk("ld5_valid", 32'(d_rsp_valid), 32'd1);
    chk("ld5_err",   32'(d_rsp_err), 32'd0);
    chk("ld5_data",  d_rsp_data, 32'hDEAD_BEEF);
    d_idle();
    tick();
    chk("ld5_pulse_end", 32'(d_rsp_valid), 32'd0);

    // fetch just past the end
    i_req_valid = 1'b1; i_req_addr = 32'd1024;
    #1;
    chk("oor_i_ready", 32'(i_req_ready), 32'd1);
    tick();
    i_req_valid = 1'b0;
    chk("oor_i_valid", 32'(i_rsp_valid), 32'd1);
    chk("oor_i_err",   32'(i_rsp_err), 32'd1);
    chk("oor_i_data",  i_rsp_data, 32'd0);

    // out-of-range store must not alias onto word 5
    d_store(BASE + 32'h0001_0005, 32'h5555_5555);
    tick();
    chk("oor_st_valid", 32'(d_rsp_valid), 32'd1);
    chk("oor_st_err",   32'(d_rsp_err), 32'd1);
    d_load(BASE + 32'd5);
    tick();
    d_idle();
    chk("oor_st_noalias", d_rsp_data, 32'hDEAD_BEEF);
    chk("ld_err_clear",   32'(d_rsp_err), 32'd0);
    tick();

    // back-to-back fetches
    for (int k = 0; k < 3; k++) begin
      i_req_valid = 1'b1; i_req_addr = BASE + 32'(k);
      tick();
      chk("b2b_i_valid", 32'(i_rsp_valid), 32'd1);
      chk("b2b_i_err",   32'(i_rsp_err), 32'd0);
      chk("b2b_i_data",  i_rsp_data, 32'h1111_0000 + 32'(k));
    end
    i_req_valid = 1'b0;
    tick();
    chk("b2b_i_end", 32'(i_rsp_valid), 32'd0);

    // contention: fetch wins every fifth cycle
    d_load(BASE + 32'd1);
    i_req_valid = 1'b1; i_req_addr = BASE + 32'd2;
    #1;
    for (int c = 1; c <= 10; c++) begin
      exp_i = ((c % 5) == 0);
      chk("arb_i_ready", 32'(i_req_ready), 32'(exp_i));
      chk("arb_d_ready", 32'(d_req_ready), 32'(!exp_i));
      tick();
      chk("arb_i_rsp", 32'(i_rsp_valid), 32'(exp_i));
      chk("arb_d_rsp", 32'(d_rsp_valid), 32'(!exp_i));
      if (exp_i) chk("arb_i_data", i_rsp_data, 32'h1111_0002);
      else       chk("arb_d_data", d_rsp_data, 32'h1111_0001);
    end
    i_req_valid = 1'b0;
    d_idle();
    tick();

    // protection boundary
    d_store(32'd10, 32'h0000_1234);
    tick();
`ifdef MIPS_MEM_WRITE_PROTECT_EN
    chk("prot_st_err", 32'(d_rsp_err), 32'd1);
`else
    chk("prot_st_err", 32'(d_rsp_err), 32'd0);
`endif
    d_load(32'd10);
    tick();
`ifdef MIPS_MEM_WRITE_PROTECT_EN
    checks++;
    assert (d_rsp_data !== 32'h0000_1234) else begin
      failures++;
      $error("FAIL prot_ld_old observed=%h expected=not_00001234", d_rsp_data);
    end
`else
    chk("prot_ld_new", d_rsp_data, 32'h0000_1234);
`endif
    d_store(32'd300, 32'hCAFE_0300);
    tick();
    chk("st300_err", 32'(d_rsp_err), 32'd0);
    d_load(32'd300);
    tick();
    chk("ld300_data", d_rsp_data, 32'hCAFE_0300);
    d_idle();
    tick();

    // reset right after a load accept, with fetch starving
    d_load(BASE + 32'd5);
    i_req_valid = 1'b1; i_req_addr = BASE + 32'd0;
    tick();
    tick();
    chk("pre_rst_cnt",   32'(dut.r_starve_cnt), 32'd2);
    chk("pre_rst_valid", 32'(d_rsp_valid), 32'd1);
    rst = 1'b1;
    d_idle();
    i_req_valid = 1'b0;
    #1;
    chk("in_rst_d_valid", 32'(d_rsp_valid), 32'd0);
    chk("in_rst_d_err",   32'(d_rsp_err), 32'd0);
    chk("in_rst_d_data",  d_rsp_data, 32'd0);
    chk("in_rst_cnt",     32'(dut.r_starve_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_d_valid", 32'(d_rsp_valid), 32'd0);
    chk("post_rst_i_valid", 32'(i_rsp_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
